// File: rtl/sc_io_pkg.sv
// Register map constants and limits for the memory-mapped I/O port bank.
package sc_io_pkg;

  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned IDX_W     = $clog2(MAX_PORTS);

  // Word offsets inside the I/O region
  localparam int unsigned OFF_OUT_DATA = 32'h00;
  localparam int unsigned OFF_OUT_SET  = 32'h08;
  localparam int unsigned OFF_OUT_CLR  = 32'h10;
  localparam int unsigned OFF_OUT_TGL  = 32'h18;
  localparam int unsigned OFF_IN_DATA  = 32'h20;
  localparam int unsigned OFF_CHG_STAT = 32'h30;
  localparam int unsigned OFF_IRQ_EN   = 32'h31;

endpackage

// File: rtl/sc_io_sync_edge.sv
// Two-flop synchroniser for one input port plus a last-value register for change detection.
module sc_io_sync_edge #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] value,
  output logic         chg_c
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] prev_q, prev_d;

  // Next state: shift the pin through s1 -> s2 -> prev
  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign value = s2_q;
  assign chg_c = (s2_q != prev_q);

endmodule

// File: rtl/sc_io_port_bank.sv
// Memory-mapped bank of output and synchronised input ports with change status and IRQ.
module sc_io_port_bank
  import sc_io_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sel,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      we,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  input  logic [NUM_IN*DATA_W-1:0]  in_port,
  output logic [NUM_OUT*DATA_W-1:0] out_port,
  output logic                      irq
);

  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [DATA_W-1:0] out_d [NUM_OUT];
  logic [DATA_W-1:0] in_val [NUM_IN];
  logic [NUM_IN-1:0] chg;
  logic [NUM_IN-1:0] chg_stat_q, chg_stat_d;
  logic [NUM_IN-1:0] irq_en_q, irq_en_d;
  logic [NUM_IN-1:0] w1c_mask;
  logic              irq_q, irq_d;

  logic [ADDR_W-1:0] addr_base;
  logic [IDX_W-1:0]  addr_idx;
  logic              wr;

  // Address split: 8-word group base and port index
  assign addr_base = addr & ~ADDR_W'(MAX_PORTS - 1);
  assign addr_idx  = addr[IDX_W-1:0];
  assign wr        = sel & we;

  // One synchroniser/change detector per input port
  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    sc_io_sync_edge #(.W(DATA_W)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (in_port[g*DATA_W +: DATA_W]),
      .value (in_val[g]),
      .chg_c (chg[g])
    );
  end

  // Pack output registers onto the flat port
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = out_q[g];
  end

  // Next state: register writes, W1C status, and IRQ from the post-update values
  always_comb begin
    for (int unsigned i = 0; i < NUM_OUT; i++) out_d[i] = out_q[i];
    irq_en_d = irq_en_q;
    w1c_mask = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (wr && (32'(addr_idx) == i)) begin
        case (addr_base)
          ADDR_W'(OFF_OUT_DATA): out_d[i] = wdata;
          ADDR_W'(OFF_OUT_SET):  out_d[i] = out_q[i] | wdata;
          ADDR_W'(OFF_OUT_CLR):  out_d[i] = out_q[i] & ~wdata;
          ADDR_W'(OFF_OUT_TGL):  out_d[i] = out_q[i] ^ wdata;
          default: ;
        endcase
      end
    end
    if (wr && (addr == ADDR_W'(OFF_CHG_STAT))) w1c_mask = wdata[NUM_IN-1:0];
    if (wr && (addr == ADDR_W'(OFF_IRQ_EN)))   irq_en_d = wdata[NUM_IN-1:0];
    // A fresh change event beats a simultaneous clear
    chg_stat_d = (chg_stat_q & ~w1c_mask) | chg;
    irq_d      = |(chg_stat_d & irq_en_d);
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
      chg_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
      chg_stat_q <= chg_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  // Combinational read mux; anything unmapped or out of range reads zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      if (addr_base == ADDR_W'(OFF_OUT_DATA)) begin
        for (int unsigned i = 0; i < NUM_OUT; i++)
          if (32'(addr_idx) == i) rdata = out_q[i];
      end
      if (addr_base == ADDR_W'(OFF_IN_DATA)) begin
        for (int unsigned i = 0; i < NUM_IN; i++)
          if (32'(addr_idx) == i) rdata = in_val[i];
      end
      if (addr == ADDR_W'(OFF_CHG_STAT)) rdata = DATA_W'(chg_stat_q);
      if (addr == ADDR_W'(OFF_IRQ_EN))   rdata = DATA_W'(irq_en_q);
    end
  end

endmodule

// File: tb/tb_sc_io_port_bank.sv
// Randomised and directed bench for sc_io_port_bank against a sample-history reference model.
module tb_sc_io_port_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic [5:0]  addr  = '0;
  logic        we    = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [95:0] in_port = '0;
  logic [95:0] out_port;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  sc_io_port_bank dut (
    .clock    (clock),
    .reset    (reset),
    .sel      (sel),
    .addr     (addr),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .in_port  (in_port),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  // Reference state: output words, last four pin samples (h[0] newest), status, enable, irq
  logic [31:0] m_out [3];
  logic [95:0] h [4];
  logic [2:0]  m_stat = '0;
  logic [2:0]  m_en   = '0;
  logic        m_irq  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // The pin value sampled two edges ago is what IN_DATA shows now
  function automatic logic [31:0] exp_read(input logic [5:0] a);
    int idx;
    idx = int'(a[2:0]);
    if ((a & 6'h38) == 6'h00 && idx < 3) return m_out[idx];
    if ((a & 6'h38) == 6'h20 && idx < 3) return h[1][idx*32 +: 32];
    if (a == 6'h30) return {29'b0, m_stat};
    if (a == 6'h31) return {29'b0, m_en};
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [2:0] w1c;
    logic [2:0] chg;
    int idx;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_out[i] = '0;
      for (int k = 0; k < 4; k++) h[k] = '0;
      m_stat = '0; m_en = '0; m_irq = 1'b0;
    end else begin
      w1c = '0;
      if (sel && we) begin
        idx = int'(addr[2:0]);
        if (idx < 3) begin
          case (addr & 6'h38)
            6'h00: m_out[idx] = wdata;
            6'h08: m_out[idx] = m_out[idx] | wdata;
            6'h10: m_out[idx] = m_out[idx] & ~wdata;
            6'h18: m_out[idx] = m_out[idx] ^ wdata;
            default: ;
          endcase
        end
        if (addr == 6'h30) w1c = wdata[2:0];
        if (addr == 6'h31) m_en = wdata[2:0];
      end
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = in_port;
      // a change becomes an event once it has passed both sync stages
      for (int i = 0; i < 3; i++) chg[i] = (h[2][i*32 +: 32] != h[3][i*32 +: 32]);
      m_stat = (m_stat & ~w1c) | chg;
      m_irq  = |(m_stat & m_en);
    end
  endtask

  // Advance one clock, update the model, compare registered outputs
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) check_val($sformatf("out_port[%0d]", i), out_port[i*32 +: 32], m_out[i]);
    check_val("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    cycle();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a);
    logic [31:0] d;
    rd(a, d);
    check_val(tag, d, exp_read(a));
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 3; i++) m_out[i] = '0;
    for (int k = 0; k < 4; k++) h[k] = '0;

    // Reset and read every offset
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    for (int a = 0; a < 64; a++) begin
      rd(6'(a), d);
      check_val($sformatf("reset_rd[%0h]", a), d, 32'h0);
      cycle();
    end

    // Set/clear/toggle on port 1
    wr(6'h01, 32'h0000_00F0); check_val("t2_data", out_port[63:32], 32'h0000_00F0);
    wr(6'h09, 32'h0000_000F); check_val("t2_set",  out_port[63:32], 32'h0000_00FF);
    wr(6'h11, 32'h0000_0030); check_val("t2_clr",  out_port[63:32], 32'h0000_00CF);
    wr(6'h19, 32'h0000_0101); check_val("t2_tgl",  out_port[63:32], 32'h0000_01CE);
    rd(6'h01, d); check_val("t2_rd", d, 32'h0000_01CE);

    // Input change latency on port 2, IRQ disabled
    in_port[95:64] = 32'h55;
    cycle();
    rd(6'h22, d); check_val("t3_in_1clk", d, 32'h0);
    cycle();
    rd(6'h22, d); check_val("t3_in_2clk", d, 32'h55);
    rd(6'h30, d); check_val("t3_stat_2clk", d, 32'h0);
    cycle();
    rd(6'h30, d); check_val("t3_stat_3clk", d, 32'h4);
    check_val("t3_irq", {31'b0, irq}, 32'h0);

    // Enable then clear
    wr(6'h31, 32'h4); check_val("t4_irq_on", {31'b0, irq}, 32'h1);
    wr(6'h30, 32'h4); check_val("t4_irq_off", {31'b0, irq}, 32'h0);
    rd(6'h30, d); check_val("t4_stat", d, 32'h0);

    // W1C colliding with a fresh change event on bit 0
    in_port[31:0] = 32'h1;
    cycle(); cycle(); cycle();
    wr(6'h31, 32'h1); check_val("t5_irq_on", {31'b0, irq}, 32'h1);
    in_port[31:0] = 32'h2;
    cycle(); cycle();
    wr(6'h30, 32'h1);
    rd(6'h30, d); check_val("t5_stat_kept", d, 32'h1);
    check_val("t5_irq_held", {31'b0, irq}, 32'h1);
    wr(6'h30, 32'h1);
    rd(6'h30, d); check_val("t5_stat_clr", d, 32'h0);

    // Ignored writes, sel=0 read, and reset during traffic
    wr(6'h07, 32'hDEAD);
    wr(6'h20, 32'hDEAD);
    rd(6'h07, d); check_val("t6_rd07", d, 32'h0);
    rd(6'h20, d); check_val("t6_rd20", d, 32'h2);
    sel = 1'b0; addr = 6'h01; #1; check_val("t6_nosel", rdata, 32'h0);
    reset = 1'b1; sel = 1'b1; we = 1'b1; addr = 6'h00; wdata = 32'hFFFF_FFFF;
    cycle();
    sel = 1'b0; we = 1'b0; reset = 1'b0;
    check_val("t6_rst_out1", out_port[63:32], 32'h0);
    check_val("t6_rst_irq", {31'b0, irq}, 32'h0);
    rd(6'h31, d); check_val("t6_rst_en", d, 32'h0);
    rd(6'h30, d); check_val("t6_rst_stat", d, 32'h0);
    cycle(); cycle(); cycle();
    rd(6'h30, d); check_val("t6_refill_stat", d, 32'h5);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        int p;
        p = int'($urandom_range(0, 2));
        in_port[p*32 +: 32] = ($urandom_range(0, 1) == 0) ? 32'(p + 1) : $urandom;
      end
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1; cycle(); reset = 1'b0;
      end else if (op < 4) begin
        logic [5:0] a;
        a = 6'($urandom_range(0, 63));
        if (op == 0) a = 6'h30;
        if (op == 1) a = 6'h31;
        wr(a, $urandom);
      end else if (op < 8) begin
        logic [5:0] a;
        a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                        : 6'($urandom_range(0, 3) * 8 + $urandom_range(0, 2));
        if (op == 7) a = 6'h30;
        rd_chk($sformatf("rand_rd[%0h]", a), a);
        cycle();
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
